// File: rtl/frame_ram_arbiter_if.sv
// Requester-side bus of the frame RAM arbiter.
// Requesters drive req/addr; the arbiter drives gnt and the return strobe.
interface frame_ram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// Frame RAM read-port arbiter: strict priority for the display fetch,
// round-robin with a starvation override for the other requesters.
module frame_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 4,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic              Clk,
  input  logic              reset_rtl_0,
  frame_ram_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     cand;
  logic              rr_hit;
  logic [IW-1:0]     win_idx;
  logic              win_v;
  logic [ADDR_W-1:0] win_addr;
  logic              lo_req;
  logic              starved;
  logic              pick_starve;
  logic              pick_disp;
  logic              pick_rr;
  logic [CW-1:0]     starve_cnt;
  logic [IW-1:0]     iss_idx;
  logic [RAM_LAT-1:0] tag_v;
  logic [IW-1:0]     tag_idx [RAM_LAT];

  assign lo_req  = |bus.req[NUM_REQ-1:1];
  assign starved = starve_cnt == CW'(STARVE_MAX);

  // Round-robin search over 1..N-1 starting after the last low-priority winner
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = rr_ptr;
    cand   = '0;
    for (int k = 1; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k - 1) % (NUM_REQ - 1) + 1);
      if (!rr_hit && bus.req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Winner select: starvation override, then display, then round-robin
  always_comb begin
    pick_starve = reset_rtl_0 && starved && rr_hit;
    pick_disp   = reset_rtl_0 && !pick_starve && bus.req[0];
    pick_rr     = reset_rtl_0 && !pick_starve && !bus.req[0] && rr_hit;
    win_v       = 1'b0;
    win_idx     = '0;
    unique case (1'b1)
      pick_starve: begin
        win_v   = 1'b1;
        win_idx = rr_idx;
      end
      pick_disp: begin
        win_v   = 1'b1;
        win_idx = '0;
      end
      pick_rr: begin
        win_v   = 1'b1;
        win_idx = rr_idx;
      end
      default: ;
    endcase
  end

  // One-hot grant and the winner's address slice
  always_comb begin
    bus.gnt  = '0;
    win_addr = '0;
    if (win_v) bus.gnt[win_idx] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) win_addr = bus.addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Issue, tag pipeline, return register and arbitration state
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      iss_idx    <= '0;
      tag_v      <= '0;
      for (int i = 0; i < RAM_LAT; i++) tag_idx[i] <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
      rr_ptr     <= IW'(NUM_REQ - 1);
      starve_cnt <= '0;
    end else begin
      ram_en  <= win_v;
      iss_idx <= win_idx;
      if (win_v) ram_addr <= win_addr;
      tag_v[0]   <= ram_en;
      tag_idx[0] <= iss_idx;
      for (int i = 1; i < RAM_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      if (tag_v[RAM_LAT-1]) begin
        bus.rvalid <= NUM_REQ'(1) << tag_idx[RAM_LAT-1];
        bus.rdata  <= ram_dout;
      end else begin
        bus.rvalid <= '0;
      end
      if (win_v && win_idx != '0) rr_ptr <= win_idx;
      if ((win_v && win_idx != '0) || !lo_req)
        starve_cnt <= '0;
      else if (win_v && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: doc/frame_ram_arbiter.md
# frame_ram_arbiter

Shares the single read port of the frame RAM between the display path and other pixel/sprite fetchers. Requester 0 is the color mapper's per-pixel fetch and has strict priority. The other requesters are round-robin, with a starvation override that guarantees forward progress. The block sits between the requesters and the frame RAM instance, runs on one clock, and returns read data tagged by a one-hot valid.

## Interface
- NUM_REQ, default 4: number of requesters (2..8); index 0 is the display.
- ADDR_W, default 19: frame RAM address width.
- DATA_W, default 4: frame RAM data width (palette index).
- RAM_LAT, default 1: RAM read latency in cycles, from ram_addr/ram_en to ram_dout.
- STARVE_MAX, default 16: cycles a low-priority request may be blocked by requester 0 before it is forced through.

Ports:
- Clk  in  1  the only clock; all state on its rising edge.
- reset_rtl_0  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request (valid).
- addr  in  NUM_REQ*ADDR_W  request addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot, combinational grant (ready); never set without the matching req.
- ram_addr  out  ADDR_W  registered address to the RAM.
- ram_en  out  1  registered read enable.
- ram_dout  in  DATA_W  RAM read data, valid RAM_LAT cycles after ram_en.
- rvalid  out  NUM_REQ  registered one-hot return strobe; one cycle per accepted request.
- rdata  out  DATA_W  registered read data, meaningful only while any rvalid bit is set.

## Operation
- Handshake: a request transfers on the rising edge that ends a cycle with req[i] && gnt[i].
  - The requester holds req[i] and its addr slice stable until that transfer.
  - It may present the next address in the following cycle; back-to-back transfers are allowed.
- Arbitration runs combinationally each cycle and selects at most one winner:
  - Starvation override: if starve_cnt == STARVE_MAX and some req[1..N-1] is high, the round-robin pick among 1..N-1 wins.
  - Otherwise, if req[0] is high, requester 0 wins.
  - Otherwise, the round-robin pick among 1..N-1 wins.
  - With no requests, gnt is 0.
- Round-robin: rr_ptr (range 1..N-1, reset value N-1) holds the last low-priority index granted.
  - The search starts at rr_ptr+1, wraps from N-1 back to 1, and never includes 0.
  - rr_ptr updates only on a low-priority transfer.
- starve_cnt (width clog2(STARVE_MAX+1), reset 0):
  - Increments on every transfer to requester 0 while any req[1..N-1] is high, saturating at STARVE_MAX.
  - Clears to 0 on any low-priority transfer, and on any cycle with no low-priority request.
- Issue: on a transfer, the next edge registers ram_addr = winner's addr, ram_en = 1, and the winner's index into a tag pipeline of depth RAM_LAT.
  - With no transfer, ram_en = 0 and ram_addr holds its previous value.
- Return: when the tag pipeline's last stage is valid, the next edge registers rdata = ram_dout and rvalid = onehot(tag); otherwise rvalid = 0 and rdata holds.
- Ordering: returns arrive strictly in issue order. There is no backpressure on returns; requesters must always accept rvalid.
- Reset (reset_rtl_0 = 0, asynchronous, at any time including mid-transfer):
  - ram_en=0, ram_addr=0, rvalid=0, rdata=0, all tag stages invalid, rr_ptr=N-1, starve_cnt=0.
  - gnt is forced to 0 while reset is low.
  - In-flight reads are discarded and never return.

## Timing
- Request accepted in cycle T → ram_en/ram_addr in T+1 → ram_dout in T+1+RAM_LAT → rvalid/rdata in T+2+RAM_LAT.
  - Default: rvalid 3 cycles after the transfer cycle.
- Throughput: one transfer per cycle, sustained indefinitely.
- gnt is combinational from req, rr_ptr and starve_cnt, with no path from ram_dout. Requesters must not make req depend combinationally on gnt.
- First grant is possible in the first cycle after reset deasserts.
- Worst-case low-priority wait with requester 0 continuously requesting: (STARVE_MAX+1)·(N-1) cycles.

## Test plan
Bench setup: NUM_REQ=4, RAM_LAT=1, STARVE_MAX=4, RAM model returns ram_dout = ram_addr[3:0].
- Lone req[2] with addr 0x00005 held one cycle at T → gnt=0100 at T; ram_en=1, ram_addr=5 at T+1; rvalid=0100, rdata=5 at T+3; all other cycles rvalid=0.
- req[0] and req[1] both high at T → gnt=0001; req[1] held → gnt=0010 in the first cycle req[0] drops; rvalid order 0001 then 0010.
- req[1..3] held high for 6 cycles with req[0] low → grants 1,2,3,1,2,3; rvalid follows the same order, 2 cycles behind ram_en.
- req[0] and req[3] held continuously → four grants to 0, grant to 3 on the 5th cycle, then starve_cnt=0 and the pattern repeats with period 5.
- Two transfers accepted, then reset_rtl_0 pulsed low for half a cycle before either returns → outputs 0 immediately, no rvalid ever appears, and a fresh lone req[1] after reset sees gnt=0010 (rr_ptr=3 wraps to 1).
- req[0] held for 100 cycles with an address incrementing on each transfer → 100 consecutive grants, ram_en high for 100 cycles, 100 rvalid=0001 strobes with rdata matching addr[3:0] in order.
